// File: rtl/csr_fetch_sequencer.sv
// rtl/csr_fetch_sequencer.sv - CSR walker feeding (value, vector) pairs to the SpMV MAC
// Optional HHT_RPTR_REUSE_EN: carry a row's end pointer forward as the next row's start.
module csr_fetch_sequencer #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NROW_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [AW-1:0]     row_base,
    input  logic [AW-1:0]     col_base,
    input  logic [AW-1:0]     val_base,
    input  logic [AW-1:0]     vec_base,
    input  logic [NROW_W-1:0] nrows,
    output logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     dataIn1,
    output logic [AW-1:0]     addr2,
    input  logic [DW-1:0]     dataIn2,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [DW-1:0]     mat_val,
    output logic [DW-1:0]     vec_val,
    output logic              row_last,
    output logic [NROW_W-1:0] row_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RPTR0, S_RPTR1, S_COL, S_VEC, S_EMIT, S_DONE
    } state_t;

    state_t state, next_state;

    logic [AW-1:0]     row_base_q, col_base_q, val_base_q, vec_base_q;
    logic [NROW_W-1:0] nrows_q, r_q;
    logic [DW-1:0]     k_q, end_q, col_q, mval_q, vval_q;
    logic              empty_q;

    logic more_in_row, more_rows, xfer;
    assign more_in_row = !empty_q && ((k_q + DW'(1)) < end_q);
    assign more_rows   = (r_q + NROW_W'(1)) < nrows_q;
    assign xfer        = (state == S_EMIT) && pair_ready;

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (nrows == '0) ? S_DONE : S_RPTR0;
            S_RPTR0: next_state = S_RPTR1;
            S_RPTR1: next_state = (k_q < dataIn1) ? S_COL : S_EMIT;
            S_COL:   next_state = S_VEC;
            S_VEC:   next_state = S_EMIT;
            S_EMIT: begin
                if (pair_ready) begin
                    if (more_in_row)
                        next_state = S_COL;
                    else if (more_rows)
`ifdef HHT_RPTR_REUSE_EN
                        next_state = S_RPTR1;
`else
                        next_state = S_RPTR0;
`endif
                    else
                        next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            row_base_q <= '0;
            col_base_q <= '0;
            val_base_q <= '0;
            vec_base_q <= '0;
            nrows_q    <= '0;
            r_q        <= '0;
            k_q        <= '0;
            end_q      <= '0;
            col_q      <= '0;
            mval_q     <= '0;
            vval_q     <= '0;
            empty_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    row_base_q <= row_base;
                    col_base_q <= col_base;
                    val_base_q <= val_base;
                    vec_base_q <= vec_base;
                    nrows_q    <= nrows;
                    r_q        <= '0;
                    k_q        <= '0;
                end
                S_RPTR0: k_q <= dataIn1;
                S_RPTR1: begin
                    end_q <= dataIn1;
                    // An empty or malformed row still emits one zero marker pair.
                    if (dataIn1 <= k_q) begin
                        empty_q <= 1'b1;
                        mval_q  <= '0;
                        vval_q  <= '0;
                    end else begin
                        empty_q <= 1'b0;
                    end
                end
                S_COL: begin
                    col_q  <= dataIn1;
                    mval_q <= dataIn2;
                end
                S_VEC: vval_q <= dataIn2;
                S_EMIT: if (xfer) begin
                    if (more_in_row) begin
                        k_q <= k_q + DW'(1);
                    end else if (more_rows) begin
                        r_q <= r_q + NROW_W'(1);
`ifdef HHT_RPTR_REUSE_EN
                        k_q <= end_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr1      = '0;
        addr2      = '0;
        pair_valid = 1'b0;
        mat_val    = '0;
        vec_val    = '0;
        row_last   = 1'b0;
        row_idx    = '0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_RPTR0: addr1 = row_base_q + AW'(r_q);
            S_RPTR1: addr1 = row_base_q + AW'(r_q) + AW'(1);
            S_COL: begin
                addr1 = col_base_q + AW'(k_q);
                addr2 = val_base_q + AW'(k_q);
            end
            S_VEC:   addr2 = vec_base_q + AW'(col_q);
            S_EMIT: begin
                pair_valid = 1'b1;
                mat_val    = mval_q;
                vec_val    = vval_q;
                row_last   = empty_q || ((k_q + DW'(1)) == end_q);
                row_idx    = r_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
